bin2bcd_disp: RTL



---
 rtl/bin2bcd_disp.sv | 111 +++++++++++
 1 files changed

// File: rtl/bin2bcd_disp.sv
// rtl/bin2bcd_disp.sv - sequential double-dabble binary-to-BCD converter for the 8-digit display.
// Optional macro BCD_SAT_EN: saturate to 9999_9999 with ovf=1 when the value exceeds 8 digits.
module bin2bcd_disp #(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [31:0]      disp_data,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t           state, state_d;
  logic [BIN_W-1:0] shreg, shreg_d;
  logic [39:0]      scratch, scratch_d, adj;
  logic [5:0]       cnt, cnt_d;
  logic             busy_d, done_d;
  logic [31:0]      disp_d;
`ifdef BCD_SAT_EN
  logic             ovf_d;
`endif

  // A digit >= 5 plus 3 never exceeds 12, so a 4-bit add without carry is enough.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
    end
  end

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    scratch_d = scratch;
    cnt_d     = cnt;
    busy_d    = busy;
    done_d    = 1'b0;
    disp_d    = disp_data;
`ifdef BCD_SAT_EN
    ovf_d     = ovf;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          shreg_d   = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = (adj << 1) | {39'd0, shreg[BIN_W-1]};
        shreg_d   = shreg << 1;
        cnt_d     = cnt + 6'd1;
        if (cnt_d == 6'(BIN_W)) state_d = LOAD;
      end
      LOAD: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef BCD_SAT_EN
        if (|scratch[39:32]) begin
          disp_d = 32'h9999_9999;
          ovf_d  = 1'b1;
        end else begin
          disp_d = scratch[31:0];
          ovf_d  = 1'b0;
        end
`else
        disp_d = scratch[31:0];
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      scratch   <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      disp_data <= '0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      scratch   <= scratch_d;
      cnt       <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      disp_data <= disp_d;
    end
  end

`ifdef BCD_SAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf <= 1'b0;
    else          ovf <= ovf_d;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
